// File: rtl/piso_pkg.sv
// Shared definitions for the PISO transmit controller: state encoding,
// frame-length derivation (PISO_TX_PARITY_EN adds a parity bit) and counter sizing.
package piso_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  function automatic int frame_len(input int width);
`ifdef PISO_TX_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, right-shifting register; load wins over shift, LSB drives out.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] d_in,
  output logic             out
);

  logic [WIDTH-1:0] q_r;

  // Shifter storage: zero fill at the MSB on every shift.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q_r <= {WIDTH{1'b0}};
    end else if (ld) begin
      q_r <= d_in;
    end else if (shift_en) begin
      q_r <= {1'b0, q_r[WIDTH-1:1]};
    end else begin
      q_r <= q_r;
    end
  end

  assign out = q_r[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// PISO transmit sequencer: handshake load, LSB-first shift-out, idle gap, done pulse.
// Optional trailing even-parity bit when PISO_TX_PARITY_EN is defined.
module piso_tx_ctrl
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int FL = frame_len(WIDTH);
  localparam int CW = cnt_width(WIDTH);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [1:0]    state_r;
  logic [1:0]    next_state_s;
  logic [CW-1:0] bit_cnt_r;
  logic [GW-1:0] gap_cnt_r;
  logic          done_r;
  logic          accept_s;
  logic          last_bit_s;
  logic          gap_end_s;
  logic          sh_out_s;
  logic          bit_s;

  assign accept_s   = in_valid && in_ready;
  assign last_bit_s = (state_r == SHIFT) && (bit_cnt_r == CW'(FL - 1));
  assign gap_end_s  = (state_r == GAP) && (gap_cnt_r == GW'(GAP_CYCLES - 1));

  piso_shift_reg #(.WIDTH(WIDTH)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .ld       (accept_s),
    .shift_en (state_r == SHIFT),
    .d_in     (in_data),
    .out      (sh_out_s)
  );

`ifdef PISO_TX_PARITY_EN
  logic par_r;

  // Even parity of the accepted word, sent after the MSB.
  always_ff @(posedge clk) begin
    if (!reset) begin
      par_r <= 1'b0;
    end else if (accept_s) begin
      par_r <= ^in_data;
    end else begin
      par_r <= par_r;
    end
  end

  assign bit_s = (bit_cnt_r == CW'(WIDTH)) ? par_r : sh_out_s;
`else
  assign bit_s = sh_out_s;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = SHIFT;
        else          next_state_s = IDLE;
      end
      SHIFT: begin
        if (last_bit_s) next_state_s = (GAP_CYCLES > 0) ? GAP : IDLE;
        else            next_state_s = SHIFT;
      end
      GAP: begin
        if (gap_end_s) next_state_s = IDLE;
        else           next_state_s = GAP;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Bit/gap counters and the registered completion pulse; reset kills a pending done.
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt_r <= {CW{1'b0}};
      gap_cnt_r <= {GW{1'b0}};
      done_r    <= 1'b0;
    end else begin
      if (accept_s) begin
        bit_cnt_r <= {CW{1'b0}};
      end else if (state_r == SHIFT) begin
        bit_cnt_r <= bit_cnt_r + CW'(1);
      end else begin
        bit_cnt_r <= bit_cnt_r;
      end
      if (state_r == GAP) begin
        gap_cnt_r <= gap_cnt_r + GW'(1);
      end else begin
        gap_cnt_r <= {GW{1'b0}};
      end
      done_r <= gap_end_s || (last_bit_s && (GAP_CYCLES == 0));
    end
  end

  // Output decode; in_ready is held low whenever reset is asserted.
  always_comb begin
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    ser_out   = 1'b0;
    busy      = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready = reset;
      end
      SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = bit_s;
        busy      = 1'b1;
      end
      GAP: begin
        busy = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  assign done = done_r;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl: expected serial bits are queued at handshake
// and popped by a monitor whenever ser_valid is seen.
module tb_piso_tx_ctrl;

  localparam int WIDTH = 4;
  localparam int GAP   = 1;
`ifdef PISO_TX_PARITY_EN
  localparam int FL = WIDTH + 1;
`else
  localparam int FL = WIDTH;
`endif
  localparam int P = 1 + FL + GAP;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] in_data = 4'h0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;

  int   total = 0;
  int   bad = 0;
  logic exp_q[$];
  logic mon_exp;

  always #5 clk = ~clk;

  piso_tx_ctrl #(.WIDTH(WIDTH), .GAP_CYCLES(GAP)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .busy      (busy),
    .done      (done)
  );

  task automatic push_word(input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
`ifdef PISO_TX_PARITY_EN
    exp_q.push_back(^w);
`endif
  endtask

  always @(negedge clk) begin
    total++;
    if (ser_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got ser_out=%b with ser_valid=1, want no frame bit", ser_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (ser_out !== mon_exp) begin
          bad++;
          $display("FAIL sb_bit: got ser_out=%b want %b at %0t", ser_out, mon_exp, $time);
        end
      end
    end else if (ser_valid !== 1'b0 || ser_out !== 1'b0) begin
      bad++;
      $display("FAIL sb_quiet: got ser_valid=%b ser_out=%b want 0/0 at %0t", ser_valid, ser_out, $time);
    end
  end

  task automatic test_reset;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got in_ready=%b done=%b busy=%b want 0/0/0", in_ready, done, busy);
      end
    end
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL idle_quiet: got in_ready=%b done=%b busy=%b want 1/0/0", in_ready, done, busy);
      end
    end
  endtask

  task automatic test_single;
    int nvalid;
    nvalid = 0;
    @(negedge clk);
    in_data = 4'b1011;
    in_valid = 1'b1;
    push_word(in_data);
    for (int c = 1; c <= FL + GAP + 2; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (ser_valid === 1'b1) nvalid++;
      total++;
      if (done !== (c == FL + GAP + 1)) begin
        bad++;
        $display("FAIL single_done: cycle %0d got done=%b want %b", c, done, (c == FL + GAP + 1));
      end
      total++;
      if (busy !== (c <= FL + GAP) || in_ready !== (c > FL + GAP)) begin
        bad++;
        $display("FAIL single_busy: cycle %0d got busy=%b in_ready=%b", c, busy, in_ready);
      end
    end
    total++;
    if (nvalid != FL || exp_q.size() != 0) begin
      bad++;
      $display("FAIL single_len: got %0d valid bits (%0d left) want %0d", nvalid, exp_q.size(), FL);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    in_data = 4'hA;
    in_valid = 1'b1;
    push_word(in_data);
    for (int c = 1; c <= 2 * P + 1; c++) begin
      @(negedge clk);
      total++;
      if (done !== (c == P || c == 2 * P)) begin
        bad++;
        $display("FAIL b2b_done: cycle %0d got done=%b", c, done);
      end
      total++;
      if (ser_valid !== ((c <= FL) || (c > P && c <= P + FL))) begin
        bad++;
        $display("FAIL b2b_valid: cycle %0d got ser_valid=%b", c, ser_valid);
      end
      if (c == P) begin
        total++;
        if (in_ready !== 1'b1) begin
          bad++;
          $display("FAIL b2b_ready: got in_ready=%b want 1 on done cycle", in_ready);
        end
        in_data = 4'h5;
        push_word(in_data);
      end
      if (c == P + 1) in_valid = 1'b0;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_drain: got %0d bits left want 0", exp_q.size());
    end
  endtask

  task automatic test_data_stability;
    @(negedge clk);
    in_data = 4'hF;
    in_valid = 1'b1;
    push_word(in_data);
    for (int c = 1; c <= FL + GAP + 1; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (c == 2) in_data = 4'h0;
    end
    total++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL stable: got done=%b left=%0d want 1/0", done, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    @(negedge clk);
    in_data = 4'hF;
    in_valid = 1'b1;
    push_word(in_data);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (ser_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: got ser_valid=%b busy=%b in_ready=%b done=%b want 0/0/0/0",
               ser_valid, busy, in_ready, done);
    end
    total++;
    if (exp_q.size() != FL - 3) begin
      bad++;
      $display("FAIL abort_bits: got %0d unsent bits want %0d", exp_q.size(), FL - 3);
    end
    exp_q.delete();
    reset = 1'b1;
    for (int c = 0; c < FL + GAP + 2; c++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL abort_nodone: got done=%b in_ready=%b want 0/1", done, in_ready);
      end
    end
    in_data = 4'b0110;
    in_valid = 1'b1;
    push_word(in_data);
    for (int c = 1; c <= FL + GAP + 1; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    total++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL abort_resume: got done=%b left=%0d want 1/0", done, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx_ctrl.md
Name: piso_tx_ctrl

Overview:
- Sequencing controller for a parallel-in/serial-out shift register.
- Accepts a parallel word over a valid/ready handshake and loads it into the shifter.
- Shifts the word out LSB-first with a serial-valid strobe, inserts a programmable idle gap, then signals completion.
- Sits between a word-producing datapath and a single-wire serial consumer.

Parameters:
- WIDTH, 4, data word width in bits; legal range 2..32.
- GAP_CYCLES, 1, idle cycles after the last serial bit before the next word can be accepted; 0 is legal.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  parallel word to transmit.
- in_valid  input  1  producer has a word on in_data.
- in_ready  output  1  controller can accept a word; high only in IDLE.
- ser_out  output  1  serial data bit, LSB first.
- ser_valid  output  1  ser_out carries a frame bit this cycle.
- busy  output  1  high in SHIFT and GAP states.
- done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, port name reset.
- Reset (reset==0 sampled at a posedge):
  - state=IDLE, bit counter=0, gap counter=0, shifter contents=0.
  - ser_out=0, ser_valid=0, done=0.
  - in_ready is forced 0 while reset is low.
- States:
  - IDLE: in_ready=1, busy=0, ser_valid=0, ser_out=0. If in_valid&&in_ready at the edge, load in_data into the shifter, clear the bit counter, go to SHIFT.
  - SHIFT: ser_valid=1, ser_out=shifter[0]. Each cycle the shifter shifts right, filling zero at the MSB, and the bit counter increments. After the final bit (count==FRAME_LEN-1), go to GAP if GAP_CYCLES>0, otherwise to IDLE.
  - GAP: ser_valid=0, ser_out=0. Counts GAP_CYCLES cycles, then goes to IDLE.
- done:
  - Registered; high for exactly the first IDLE cycle after a completed frame.
  - Never asserted after reset or after an aborted frame.
- Timing (accept at cycle 0):
  - Bit i appears on cycles 1..FRAME_LEN.
  - Gap occupies the next GAP_CYCLES cycles.
  - done is high on cycle FRAME_LEN+GAP_CYCLES+1.
- Back-to-back words: in_ready is high in the same cycle as done, so a word can be accepted then. Sustained period is 1+FRAME_LEN+GAP_CYCLES cycles.
- Data stability: in_data is sampled only at handshake. Later changes on in_data have no effect on the frame in flight.
- in_valid low in IDLE: stay in IDLE indefinitely, outputs quiet.
- Reset mid-frame (reset low in SHIFT or GAP): the next edge aborts the frame, returns to reset values and drops ser_valid immediately. No partial done.
- Counter width: $clog2(WIDTH+2). Wrap never occurs because the FSM exits SHIFT at count==FRAME_LEN-1.
- FRAME_LEN = WIDTH, or WIDTH+1 with the optional feature enabled.

Optional Feature:
- Macro: PISO_TX_PARITY_EN.
- Defined:
  - At load, the even-parity bit (XOR of in_data) is captured.
  - It is sent as an extra serial bit after the MSB, with ser_valid=1.
  - FRAME_LEN=WIDTH+1.
- Undefined: no parity logic exists; FRAME_LEN=WIDTH.

Decomposition:
- Shared package/include piso_pkg:
  - State encoding localparams: IDLE=2'd0, SHIFT=2'd1, GAP=2'd2.
  - FRAME_LEN derivation macro.
  - Counter-width function.
- Sub-module piso_shift_reg:
  - Ports: clk, reset, ld, shift_en, d_in[WIDTH], out.
  - Synchronous active-low reset.
  - ld has priority over shift_en.
  - out=q[0].
- piso_tx_ctrl holds the FSM, counters, handshake and the optional parity bit, and instantiates one piso_shift_reg.

Test Plan:
- Reset then idle, in_valid=0 for 10 cycles -> in_ready=1, ser_valid=0, ser_out=0, done=0 throughout.
- WIDTH=4, GAP_CYCLES=1, send 4'b1011 -> ser_out 1,1,0,1 on cycles 1-4 with ser_valid=1; cycle 5 gap; done=1 on cycle 6 only.
- Back-to-back 4'hA then 4'h5 with in_valid held high -> bits 0,1,0,1 then 1,0,1,0. Second accept occurs on the done cycle; period is 6 cycles.
- Change in_data from 4'hF to 4'h0 on cycle 2 of a frame -> frame still emits 1,1,1,1.
- Assert reset low on cycle 3 of a 4'b1111 frame -> ser_valid=0 on the next cycle, no done, and a new word is accepted after reset releases.
- With PISO_TX_PARITY_EN, send 4'b1011 -> 5 valid bits 1,1,0,1,1; done on cycle 7 (GAP_CYCLES=1). Without the macro, the same word gives 4 bits.
